// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared branch-prediction definitions used by the BHT and the
//                branch resolve unit: 2-bit counter encoding, the saturating
//                counter step function and the pipeline tracking entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int c_PC_W = 32;

    // 2-bit saturating counter encoding, MSB is the predicted direction
    localparam logic [1:0] SNT = 2'b00;  // strongly not taken
    localparam logic [1:0] WNT = 2'b01;  // weakly not taken
    localparam logic [1:0] WT  = 2'b10;  // weakly taken
    localparam logic [1:0] ST  = 2'b11;  // strongly taken

    // Prediction carried alongside an instruction from IF to EX
    typedef struct packed {
        logic              valid;
        logic [c_PC_W-1:0] pc;
        logic              pred_taken;
        logic [1:0]        ctr;
        logic [c_PC_W-1:0] pred_target;
    } bp_entry_t;

    // One training step: move toward ST on taken, toward SNT otherwise
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] v_res;
        if (taken) begin
            v_res = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            v_res = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit_if
//  Description : Fetch-side prediction inputs, EX-side resolution inputs and
//                flush / redirect / BHT write-back / statistics outputs of the
//                branch resolve unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if #(
    parameter int IDX_W = 10,
    parameter int CNT_W = 32
) ();
    logic             if_valid;
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic [1:0]       if_pred_ctr;
    logic [31:0]      if_pred_target;
    logic             stall;
    logic             ex_is_branch;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             upd_we;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_ctr;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] miss_count;

    // Pipeline / test driver side
    modport master (
        output if_valid, if_pc, if_pred_taken, if_pred_ctr, if_pred_target,
        output stall, ex_is_branch, ex_taken, ex_target,
        input  flush, redirect_valid, redirect_pc,
        input  upd_we, upd_idx, upd_ctr, br_count, miss_count
    );

    // Branch resolve unit side
    modport slave (
        input  if_valid, if_pc, if_pred_taken, if_pred_ctr, if_pred_target,
        input  stall, ex_is_branch, ex_taken, ex_target,
        output flush, redirect_valid, redirect_pc,
        output upd_we, upd_idx, upd_ctr, br_count, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bp_sat_counter
//  Description : Combinational 2-bit saturating counter step, shared with the
//                BHT for in-table updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter
    import bp_pkg::*;
(
    input  wire logic [1:0] i_ctr,
    input  wire logic       i_taken,
    output logic      [1:0] o_ctr
);

    assign o_ctr = ctr_next(i_ctr, i_taken);

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Carries each instruction's branch prediction through ID and
//                EX, detects mispredicts in EX (flush + redirect), writes the
//                trained counter back to the BHT one cycle later and keeps
//                saturating branch / mispredict statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    branch_resolve_unit_if.slave  bus
);

    bp_entry_t        r_id;
    bp_entry_t        r_ex;
    logic             r_upd_we;
    logic [IDX_W-1:0] r_upd_idx;
    logic [1:0]       r_upd_ctr;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_miss_count;

    bp_entry_t        w_if_entry;
    logic             w_resolve;
    logic             w_dir_miss;
    logic             w_tgt_miss;
    logic             w_mispredict;
    logic [31:0]      w_fallthru;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_fwd;
    logic [1:0]       w_base_ctr;
    logic [1:0]       w_new_ctr;

    assign w_if_entry = '{valid:       bus.if_valid,
                          pc:          bus.if_pc,
                          pred_taken:  bus.if_pred_taken,
                          ctr:         bus.if_pred_ctr,
                          pred_target: bus.if_pred_target};

    // A redirect kills ID and blocks the ID->EX move; a stall only bubbles EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id <= '0;
            r_ex <= '0;
        end else begin
            if (w_mispredict) begin
                r_id.valid <= 1'b0;
            end else if (!bus.stall) begin
                r_id <= w_if_entry;
            end
            if (w_mispredict || bus.stall) begin
                r_ex.valid <= 1'b0;
            end else begin
                r_ex <= r_id;
            end
        end
    end

    // Only a live conditional branch in EX is resolved
    assign w_resolve    = r_ex.valid & bus.ex_is_branch;
    assign w_dir_miss   = r_ex.pred_taken != bus.ex_taken;
    assign w_tgt_miss   = r_ex.pred_taken & bus.ex_taken & (r_ex.pred_target != bus.ex_target);
    assign w_mispredict = w_resolve & (w_dir_miss | w_tgt_miss);
    assign w_fallthru   = r_ex.pc + 32'd4;

    assign bus.flush          = w_mispredict;
    assign bus.redirect_valid = w_mispredict;
    assign bus.redirect_pc    = w_mispredict ? (bus.ex_taken ? bus.ex_target : w_fallthru) : 32'd0;

    // The counter snapshot taken in IF is stale if the same entry is being
    // written back right now, so use the value in flight instead
    assign w_ex_idx   = r_ex.pc[IDX_W+1:2];
    assign w_fwd      = r_upd_we & (r_upd_idx == w_ex_idx);
    assign w_base_ctr = w_fwd ? r_upd_ctr : r_ex.ctr;

    bp_sat_counter u_sat_counter (
        .i_ctr   (w_base_ctr),
        .i_taken (bus.ex_taken),
        .o_ctr   (w_new_ctr)
    );

    // BHT write-back, one cycle after resolution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_we  <= 1'b0;
            r_upd_idx <= '0;
            r_upd_ctr <= SNT;
        end else begin
            r_upd_we <= w_resolve;
            if (w_resolve) begin
                r_upd_idx <= w_ex_idx;
                r_upd_ctr <= w_new_ctr;
            end
        end
    end

    // Saturating branch and mispredict statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_resolve && !(&r_br_count)) begin
                r_br_count <= r_br_count + 1'b1;
            end
            if (w_mispredict && !(&r_miss_count)) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    assign bus.upd_we     = r_upd_we;
    assign bus.upd_idx    = r_upd_idx;
    assign bus.upd_ctr    = r_upd_ctr;
    assign bus.br_count   = r_br_count;
    assign bus.miss_count = r_miss_count;

endmodule
`default_nettype wire
